dsp_issue_sched: RTL and testbench

Upstream operand scheduler for the fracturable `DSP_top` multiplier. It accepts multiply and MAC requests on a valid/ready stream and buffers them in a 2-entry queue. It drives `start`, `mode`, `mac`, `aa`, `bb`, `cc` and `shift_amount` into the DSP at the mode-legal issue interval: every cycle in mode 0, every 2 cycles in mode 1, every 4 cycles in mode 2. It also tracks in-flight operations and flags the cycle in which the DSP `out` carries each result.

---
 rtl/dsp_issue_sched.sv | 185 ++++++++++++++++++
 tb/tb_dsp_issue_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_issue_sched.sv
// Operand scheduler for the fracturable DSP multiplier: 2-entry request queue, mode-paced issue, result-slot tracker.
// Define DSP_ISSUE_STATS_EN to add the issue_cnt / stall_cnt counters.
module dsp_issue_sched #(
  parameter int N      = 32,
  parameter int LAT_M0 = 2,
  parameter int LAT_M1 = 3,
  parameter int LAT_M2 = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_mode,
  input  logic           in_mac,
  input  logic [N-1:0]   in_aa,
  input  logic [N-1:0]   in_bb,
  input  logic [2*N-1:0] in_cc,
  input  logic [1:0]     in_shift,
  output logic           start,
  output logic [1:0]     mode,
  output logic           mac,
  output logic [N-1:0]   aa,
  output logic [N-1:0]   bb,
  output logic [2*N-1:0] cc,
  output logic [1:0]     shift_amount,
  output logic           res_valid,
  output logic           busy
`ifdef DSP_ISSUE_STATS_EN
  ,
  output logic [15:0]    issue_cnt,
  output logic [15:0]    stall_cnt
`endif
);

  typedef struct packed {
    logic [1:0]     mode;
    logic           mac;
    logic [N-1:0]   aa;
    logic [N-1:0]   bb;
    logic [2*N-1:0] cc;
    logic [1:0]     shift;
  } entry_t;

  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? 2'd2 : m;
  endfunction

  function automatic logic [3:0] lat_of(input logic [1:0] m);
    case (m)
      2'd0:    lat_of = 4'(LAT_M0);
      2'd1:    lat_of = 4'(LAT_M1);
      default: lat_of = 4'(LAT_M2);
    endcase
  endfunction

  // Cycles to wait after an issue before the next one: interval minus one.
  function automatic logic [1:0] cool_of(input logic [1:0] m);
    case (m)
      2'd0:    cool_of = 2'd0;
      2'd1:    cool_of = 2'd1;
      default: cool_of = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] cool_dec(input logic [1:0] c);
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  entry_t     mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] cool_q, cool_d;
  logic [1:0] cur_mode_q, cur_mode_d;
  logic [8:0] trk_q, trk_d;
  entry_t     out_q, out_d;
  logic       start_q, start_d;

  entry_t     head;
  entry_t     push_ent;
  logic       push;
  logic       pop;
  logic       trk_drained;

  always_comb begin
    head        = mem_q[rd_ptr_q];
    // Bits above 0 are the results still pending after this edge; a mode
    // change may issue once only the final res_valid cycle remains.
    trk_drained = (trk_q[8:1] == 8'd0);
    pop         = (cnt_q != 2'd0) && (cool_q == 2'd0) &&
                  ((head.mode == cur_mode_q) || trk_drained);
    in_ready    = (cnt_q != 2'd2) || pop;
    push        = in_valid && in_ready;
    push_ent    = {norm_mode(in_mode), in_mac, in_aa, in_bb, in_cc, in_shift};

    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    start_d     = 1'b0;
    out_d       = out_q;
    cur_mode_d  = cur_mode_q;
    cool_d      = cool_dec(cool_q);
    trk_d       = {1'b0, trk_q[8:1]};
    if (pop) begin
      start_d    = 1'b1;
      out_d      = head;
      cur_mode_d = head.mode;
      cool_d     = cool_of(head.mode);
      trk_d      = trk_d | (9'd1 << lat_of(head.mode));
    end
  end

  // Queue storage carries data only; occupancy is owned by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      cool_q     <= 2'd0;
      cur_mode_q <= 2'd0;
      trk_q      <= 9'd0;
      out_q      <= '0;
      start_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      cool_q     <= cool_d;
      cur_mode_q <= cur_mode_d;
      trk_q      <= trk_d;
      out_q      <= out_d;
      start_q    <= start_d;
    end
  end

  assign start        = start_q;
  assign mode         = out_q.mode;
  assign mac          = out_q.mac;
  assign aa           = out_q.aa;
  assign bb           = out_q.bb;
  assign cc           = out_q.cc;
  assign shift_amount = out_q.shift;
  assign res_valid    = trk_q[0];
  assign busy         = (cnt_q != 2'd0) | (trk_q != 9'd0) | (cool_q != 2'd0);

`ifdef DSP_ISSUE_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop) begin
      issue_cnt_d = issue_cnt_q + 16'd1;
    end else if (cnt_q != 2'd0) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dsp_issue_sched.sv
// Bench for dsp_issue_sched: vector table, directed corner sequences and random traffic against a timestamp model.
module tb_dsp_issue_sched;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst_n, in_valid, in_ready, in_mac;
  logic [1:0]     in_mode, in_shift;
  logic [N-1:0]   in_aa, in_bb;
  logic [2*N-1:0] in_cc;
  logic           start, mac, res_valid, busy;
  logic [1:0]     mode, shift_amount;
  logic [N-1:0]   aa, bb;
  logic [2*N-1:0] cc;
`ifdef DSP_ISSUE_STATS_EN
  logic [15:0]    issue_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  dsp_issue_sched #(.N(N), .LAT_M0(2), .LAT_M1(3), .LAT_M2(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_mac(in_mac), .in_aa(in_aa), .in_bb(in_bb),
    .in_cc(in_cc), .in_shift(in_shift), .start(start), .mode(mode),
    .mac(mac), .aa(aa), .bb(bb), .cc(cc), .shift_amount(shift_amount),
    .res_valid(res_valid), .busy(busy)
`ifdef DSP_ISSUE_STATS_EN
    , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic [1:0]     mode;
    logic           mac;
    logic [N-1:0]   aa;
    logic [N-1:0]   bb;
    logic [2*N-1:0] cc;
    logic [1:0]     sh;
  } req_t;

  typedef struct {
    bit          rst;
    bit          v;
    logic [1:0]  mode;
    logic [31:0] aa;
    bit          e_rdy;
    bit          e_start;
    bit          e_res;
    logic [31:0] e_aa;
  } vec_t;

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  // Reference model: pending requests plus timestamps of the last issue and latest result.
  req_t mq[$];
  int   res_q[$];
  int   cyc = 0;
  int   last_start, max_res, cur_m;
  req_t held;
  int   m_issue, m_stall;

  int   n_start, n_res, first_start, last_start_mon, first_res;

  function automatic int lat(int m);
    return (m == 0) ? 2 : (m == 1) ? 3 : 5;
  endfunction

  function automatic int ivl(int m);
    return (m == 0) ? 1 : (m == 1) ? 2 : 4;
  endfunction

  function automatic req_t mkreq(logic [1:0] m, logic [N-1:0] a);
    req_t r;
    r.mode = m;
    r.mac  = a[0];
    r.aa   = a;
    r.bb   = a + 1;
    r.cc   = {a, ~a};
    r.sh   = a[2:1];
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    res_q.delete();
    last_start = -100;
    max_res    = -100;
    cur_m      = 0;
    held       = '{default: '0};
    m_issue    = 0;
    m_stall    = 0;
  endtask

  task automatic clr_mon();
    n_start = 0; n_res = 0; first_start = -1; last_start_mon = -1; first_res = -1;
  endtask

  task automatic tick(input bit rst, input bit v, input req_t r, output logic rdy_s);
    bit   iss;
    bit   rdy_exp;
    bit   e_res;
    bit   e_busy;
    req_t pr;
    rst_n    = !rst;
    in_valid = v;
    in_mode  = r.mode;
    in_mac   = r.mac;
    in_aa    = r.aa;
    in_bb    = r.bb;
    in_cc    = r.cc;
    in_shift = r.sh;
    iss = 1'b0;
    if (mq.size() > 0)
      iss = (cyc + 1 - last_start >= ivl(cur_m)) &&
            ((int'(mq[0].mode) == cur_m) || (cyc + 1 > max_res));
    rdy_exp = (mq.size() < 2) || iss;
    @(negedge clk);
    rdy_s = in_ready;
    if (armed) chk("in_ready", in_ready, rdy_exp);
    if (!rst) begin
      if (iss) m_issue++;
      else if (mq.size() > 0) m_stall++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      model_reset();
      iss = 1'b0;
    end else begin
      if (iss) begin
        held       = mq.pop_front();
        last_start = cyc;
        cur_m      = int'(held.mode);
        max_res    = cyc + lat(cur_m);
        res_q.push_back(max_res);
      end
      if (v && rdy_exp) begin
        pr = r;
        if (pr.mode == 2'd3) pr.mode = 2'd2;
        mq.push_back(pr);
      end
    end
    e_res = 1'b0;
    if (res_q.size() > 0 && res_q[0] == cyc) begin
      e_res = 1'b1;
      void'(res_q.pop_front());
    end
    e_busy = (mq.size() > 0) || (max_res >= cyc) || (cyc - last_start < ivl(cur_m) - 1);
    chk("start", start, iss);
    chk("res_valid", res_valid, e_res);
    chk("busy", busy, e_busy);
    chk("mode", mode, held.mode);
    chk("mac", mac, held.mac);
    chk("aa", aa, held.aa);
    chk("bb", bb, held.bb);
    chk("cc", cc, held.cc);
    chk("shift_amount", shift_amount, held.sh);
`ifdef DSP_ISSUE_STATS_EN
    chk("issue_cnt", issue_cnt, 64'(m_issue[15:0]));
    chk("stall_cnt", stall_cnt, 64'(m_stall[15:0]));
`endif
    if (start === 1'b1) begin
      n_start++;
      if (first_start < 0) first_start = cyc;
      last_start_mon = cyc;
    end
    if (res_valid === 1'b1) begin
      n_res++;
      if (first_res < 0) first_res = cyc;
    end
  endtask

  function automatic vec_t mk(bit rst, bit v, logic [1:0] m, logic [31:0] a,
                              bit rdy, bit st, bit rs, logic [31:0] ea);
    vec_t t;
    t.rst = rst; t.v = v; t.mode = m; t.aa = a;
    t.e_rdy = rdy; t.e_start = st; t.e_res = rs; t.e_aa = ea;
    return t;
  endfunction

  vec_t tbl[25];
  req_t idle;
  logic rdy;
  int   k;
  logic [1:0] rm;

  initial begin
    // Mode-2 spacing with back-pressure (aa=30 sent as mode 3), then a 0->1 mode change.
    tbl[0]  = mk(1, 0, 2'd0, 0,  1, 0, 0, 0);
    tbl[1]  = mk(0, 1, 2'd2, 10, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 2'd2, 20, 1, 1, 0, 10);
    tbl[3]  = mk(0, 1, 2'd3, 30, 1, 0, 0, 10);
    tbl[4]  = mk(0, 1, 2'd2, 99, 0, 0, 0, 10);
    tbl[5]  = mk(0, 1, 2'd2, 99, 0, 0, 0, 10);
    tbl[6]  = mk(0, 0, 2'd2, 0,  1, 1, 0, 20);
    tbl[7]  = mk(0, 0, 2'd2, 0,  1, 0, 1, 20);
    tbl[8]  = mk(0, 0, 2'd2, 0,  1, 0, 0, 20);
    tbl[9]  = mk(0, 0, 2'd2, 0,  1, 0, 0, 20);
    tbl[10] = mk(0, 0, 2'd2, 0,  1, 1, 0, 30);
    tbl[11] = mk(0, 0, 2'd2, 0,  1, 0, 1, 30);
    tbl[12] = mk(0, 0, 2'd2, 0,  1, 0, 0, 30);
    tbl[13] = mk(0, 0, 2'd2, 0,  1, 0, 0, 30);
    tbl[14] = mk(0, 0, 2'd2, 0,  1, 0, 0, 30);
    tbl[15] = mk(0, 0, 2'd2, 0,  1, 0, 1, 30);
    tbl[16] = mk(1, 0, 2'd0, 0,  1, 0, 0, 0);
    tbl[17] = mk(0, 1, 2'd0, 1,  1, 0, 0, 0);
    tbl[18] = mk(0, 1, 2'd1, 2,  1, 1, 0, 1);
    tbl[19] = mk(0, 0, 2'd0, 0,  1, 0, 0, 1);
    tbl[20] = mk(0, 0, 2'd0, 0,  1, 0, 1, 1);
    tbl[21] = mk(0, 0, 2'd0, 0,  1, 1, 0, 2);
    tbl[22] = mk(0, 0, 2'd0, 0,  1, 0, 0, 2);
    tbl[23] = mk(0, 0, 2'd0, 0,  1, 0, 0, 2);
    tbl[24] = mk(0, 0, 2'd0, 0,  1, 0, 1, 2);

    idle = mkreq(2'd0, '0);
    model_reset();
    clr_mon();
    tick(1, 0, idle, rdy);
    tick(1, 0, idle, rdy);
    armed = 1'b1;

    for (int i = 0; i < 25; i++) begin
      tick(tbl[i].rst, tbl[i].v, mkreq(tbl[i].mode, tbl[i].aa), rdy);
      if (!tbl[i].rst) chk($sformatf("tbl%0d_rdy", i), rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_start", i), start, tbl[i].e_start);
      chk($sformatf("tbl%0d_res", i), res_valid, tbl[i].e_res);
      chk($sformatf("tbl%0d_aa", i), aa, tbl[i].e_aa);
    end

    // Mode-0 back-to-back stream.
    tick(1, 0, idle, rdy);
    clr_mon();
    for (int i = 0; i < 8; i++) tick(0, 1, mkreq(2'd0, 32'(i)), rdy);
    for (int i = 0; i < 6; i++) tick(0, 0, idle, rdy);
    chk("m0_starts", 64'(n_start), 64'd8);
    chk("m0_start_span", 64'(last_start_mon - first_start), 64'd7);
    chk("m0_results", 64'(n_res), 64'd8);
    chk("m0_first_res_lat", 64'(first_res - first_start), 64'd2);

    // Reset one cycle after a mode-2 start.
    tick(1, 0, idle, rdy);
    clr_mon();
    tick(0, 1, mkreq(2'd2, 32'h5), rdy);
    tick(0, 0, idle, rdy);
    chk("rmf_started", start, 1'b1);
    tick(0, 0, idle, rdy);
    tick(1, 0, idle, rdy);
    chk("rmf_busy", busy, 1'b0);
    chk("rmf_start", start, 1'b0);
    chk("rmf_aa", aa, '0);
    for (int i = 0; i < 8; i++) tick(0, 0, idle, rdy);
    chk("rmf_no_result", 64'(n_res), 64'd0);

    // Full mode-1 queue with sustained valid: ready only on issue cycles.
    tick(1, 0, idle, rdy);
    clr_mon();
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, mkreq(2'd1, 32'(100 + k)), rdy);
      if (rdy) k++;
      if (i >= 4) chk("full_rdy_is_issue", rdy, start);
    end
    for (int i = 0; i < 12; i++) tick(0, 0, idle, rdy);
    chk("full_no_loss", 64'(n_start), 64'(k));
    chk("full_results", 64'(n_res), 64'(k));

`ifdef DSP_ISSUE_STATS_EN
    tick(1, 0, idle, rdy);
    k = 0;
    while (k < 4) begin
      tick(0, 1, mkreq(2'd1, 32'(200 + k)), rdy);
      if (rdy) k++;
    end
    for (int i = 0; i < 10; i++) tick(0, 0, idle, rdy);
    chk("stats_issue", issue_cnt, 64'd4);
    chk("stats_stall", stall_cnt, 64'd3);
`endif

    // Random traffic with sticky modes and rare resets.
    tick(1, 0, idle, rdy);
    rm = 2'd0;
    for (int i = 0; i < 600; i++) begin
      req_t r;
      if ($urandom_range(0, 5) == 0) rm = 2'($urandom_range(0, 3));
      r.mode = rm;
      r.mac  = 1'($urandom_range(0, 1));
      r.aa   = $urandom;
      r.bb   = $urandom;
      r.cc   = {$urandom, $urandom};
      r.sh   = 2'($urandom_range(0, 3));
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, r, rdy);
    end
    for (int i = 0; i < 12; i++) tick(0, 0, idle, rdy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
